// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and types for the shared run detector.
//   - DEF_NUM_CH / DEF_LEN_W / DEF_MIN_RUN : default top-level parameters
//   - CNT_W  : width of the optional per-channel detection counters
//   - ch_w() : channel-index width for a given channel count
//   - ctx_state_e / ctx_decode() : debug/coverage view of a run context
package seq_det_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_MIN_RUN = 2;
  localparam int CNT_W       = 16;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    CTX_IDLE     = 2'd0,
    CTX_ONE_SEEN = 2'd1,
    CTX_ARMED    = 2'd2
  } ctx_state_e;

  // ARMED means a 0 arriving now would be reported.
  function automatic ctx_state_e ctx_decode(input int run, input int min_run);
    if (run >= min_run) return CTX_ARMED;
    if (run > 0)        return CTX_ONE_SEEN;
    return CTX_IDLE;
  endfunction

endpackage

// File: rtl/seq_rr_arbiter.sv
// seq_rr_arbiter: combinational round-robin pick.
//   req   : per-channel request
//   ptr   : channel with highest priority this cycle
//   grant : one-hot winner (0 when no request)
//   idx   : encoded winner
//   any   : some request was granted
module seq_rr_arbiter
  import seq_det_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  // Walk from ptr upward with wrap; first requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (int'(ptr) + k) % NUM_CH;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/seq_run_scheduler.sv
// seq_run_scheduler: one "run of >= MIN_RUN ones then a zero" detector
// time-shared over NUM_CH serial channels. Each channel's run length is kept
// as a saved context; one bit per cycle is granted round-robin.
// Ports:
//   clk, reset (async, active low)
//   ch_en/ch_valid/ch_bit : per-channel enable, bit offer, bit value
//   ch_ready              : one-hot combinational grant
//   flush                 : sync clear of contexts and pointer
//   det_valid/det_ch/det_len : registered detection report
// Optional (macro SEQ_DET_COUNT_EN): per-channel 16-bit saturating detection
// counters, read combinationally through cnt_sel/cnt_data.
module seq_run_scheduler
  import seq_det_pkg::*;
#(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int LEN_W   = DEF_LEN_W,
  parameter  int MIN_RUN = DEF_MIN_RUN,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  input  logic              flush,
`ifdef SEQ_DET_COUNT_EN
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_data,
`endif
  output logic              det_valid,
  output logic [CH_W-1:0]   det_ch,
  output logic [LEN_W-1:0]  det_len
);

  logic [NUM_CH-1:0][LEN_W-1:0] r_ctx;
  logic [CH_W-1:0]              r_ptr;
  logic                         r_det_valid;
  logic [CH_W-1:0]              r_det_ch;
  logic [LEN_W-1:0]             r_det_len;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic [LEN_W-1:0]  w_run;

  // Reset gating keeps ch_ready low while reset is held even though the
  // grant is otherwise purely combinational.
  assign w_req = ch_en & ch_valid & {NUM_CH{reset & ~flush}};

  seq_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  assign ch_ready = w_grant;
  assign w_run    = r_ctx[w_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctx       <= '0;
      r_ptr       <= '0;
      r_det_valid <= 1'b0;
      r_det_ch    <= '0;
      r_det_len   <= '0;
    end else begin
      r_det_valid <= 1'b0;
      if (flush) begin
        r_ctx <= '0;
        r_ptr <= '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          // Disabled channels drop any partial run without reporting it.
          if (!ch_en[i])
            r_ctx[i] <= '0;
          else if (w_grant[i])
            r_ctx[i] <= !ch_bit[i] ? '0 :
                        (&r_ctx[i]) ? r_ctx[i] : r_ctx[i] + LEN_W'(1);
        end
        if (w_any) begin
          r_ptr <= (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + CH_W'(1);
          if (!ch_bit[w_idx] && (w_run >= LEN_W'(MIN_RUN))) begin
            r_det_valid <= 1'b1;
            r_det_ch    <= w_idx;
            r_det_len   <= w_run;
          end
        end
      end
    end
  end

  assign det_valid = r_det_valid;
  assign det_ch    = r_det_ch;
  assign det_len   = r_det_len;

`ifdef SEQ_DET_COUNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;

  // Counts the reported pulse, so it trails det_valid by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (flush)
      r_cnt <= '0;
    else if (r_det_valid && !(&r_cnt[r_det_ch]))
      r_cnt[r_det_ch] <= r_cnt[r_det_ch] + CNT_W'(1);
  end

  assign cnt_data = r_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_run_scheduler.sv
module tb_seq_run_scheduler;
  import seq_det_pkg::*;

  localparam int NCH = 4;
  localparam int LW  = 4;
  localparam int MR  = 2;
  localparam int CW  = 2;
  localparam int MAXLEN = (1 << LW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH-1:0] ch_valid = '0;
  logic [NCH-1:0] ch_bit = '0;
  logic [NCH-1:0] ch_ready;
  logic           flush = 1'b0;
  logic           det_valid;
  logic [CW-1:0]  det_ch;
  logic [LW-1:0]  det_len;
`ifdef SEQ_DET_COUNT_EN
  logic [CW-1:0]  cnt_sel = '0;
  logic [15:0]    cnt_data;
`endif

  always #5 clk = ~clk;

  seq_run_scheduler #(.NUM_CH(NCH), .LEN_W(LW), .MIN_RUN(MR)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_en     (ch_en),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_ready  (ch_ready),
    .flush     (flush),
`ifdef SEQ_DET_COUNT_EN
    .cnt_sel   (cnt_sel),
    .cnt_data  (cnt_data),
`endif
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .det_len   (det_len)
  );

  typedef struct { int ch; int len; } det_t;

  int   tests = 0;
  int   fails = 0;
  bit   bq[NCH][$];     // pending bits per channel
  det_t sb[$];          // expected detections
  int   mctx[NCH];
  int   mptr;
  int   det_seen;
  int   last_ch, last_len;
  logic [NCH-1:0] last_rdy;

  function automatic logic [NCH-1:0] exp_grant();
    logic [NCH-1:0] g;
    g = '0;
    if (reset && !flush)
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (mptr + k) % NCH;
        if (g == '0 && ch_en[c] && ch_valid[c]) g[c] = 1'b1;
      end
    return g;
  endfunction

  // Detection monitor: every pulse must match the next expected entry.
  always @(negedge clk) begin
    if (reset && det_valid) begin
      det_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_det: got ch=%0d len=%0d, none expected", det_ch, det_len);
      end else begin
        e = sb.pop_front();
        if (det_ch !== CW'(e.ch) || det_len !== LW'(e.len)) begin
          fails++;
          $display("FAIL det_value: got ch=%0d len=%0d, want ch=%0d len=%0d",
                   det_ch, det_len, e.ch, e.len);
        end
      end
      det_seen++;
      last_ch  = int'(det_ch);
      last_len = int'(det_len);
    end
  end

  // One clock: offer queued bits, check grant, advance the model.
  task automatic cycle();
    logic [NCH-1:0] eg;
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i] = (bq[i].size() > 0);
      ch_bit[i]   = (bq[i].size() > 0) ? bq[i][0] : 1'b0;
    end
    #1;
    eg = exp_grant();
    tests++;
    if (ch_ready !== eg) begin
      fails++;
      $display("FAIL grant: got %b, want %b", ch_ready, eg);
    end
    last_rdy = ch_ready;
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < NCH; i++) mctx[i] = 0;
      mptr = 0;
    end else begin
      for (int i = 0; i < NCH; i++) if (!ch_en[i]) mctx[i] = 0;
      for (int g = 0; g < NCH; g++) if (eg[g]) begin
        bit b;
        b = bq[g].pop_front();
        if (b) mctx[g] = (mctx[g] < MAXLEN) ? mctx[g] + 1 : MAXLEN;
        else begin
          if (mctx[g] >= MR) sb.push_back('{g, mctx[g]});
          mctx[g] = 0;
        end
        mptr = (g + 1) % NCH;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int maxc);
    int n;
    bit busy;
    n = 0;
    do begin
      busy = 0;
      for (int i = 0; i < NCH; i++) if (bq[i].size() > 0) busy = 1;
      if (busy && n < maxc) begin cycle(); n++; end
    end while (busy && n < maxc);
    if (busy) begin
      tests++; fails++;
      $display("FAIL run_timeout: bits still pending after %0d cycles", maxc);
      for (int i = 0; i < NCH; i++) bq[i].delete();
    end
    cycle(); cycle();
  endtask

  task automatic push(input int ch, input string bits);
    for (int i = 0; i < bits.len(); i++) bq[ch].push_back(bits[i] == "1");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    ch_valid = '0;
    for (int i = 0; i < NCH; i++) begin bq[i].delete(); mctx[i] = 0; end
    mptr = 0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missed_det: %0d expected detections never seen, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ch_en = '1; ch_valid = '1; flush = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ch_ready !== 4'b0000 || det_valid !== 1'b0 || det_ch !== '0 || det_len !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b dv=%b ch=%0d len=%0d, want 0 0 0 0",
               ch_ready, det_valid, det_ch, det_len);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ch_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_grant: got %b, want 0001", ch_ready);
    end
    ch_valid = '0;
    mptr = 0;
  endtask

  task automatic test_single();
    int d0;
    do_reset();
    ch_en = 4'b0100;
    d0 = det_seen;
    push(2, "110"); run(20);
    tests++;
    if (det_seen - d0 != 1 || last_ch != 2 || last_len != 2) begin
      fails++;
      $display("FAIL single_det: n=%0d ch=%0d len=%0d, want 1 2 2", det_seen - d0, last_ch, last_len);
    end
    d0 = det_seen;
    push(2, "10"); run(20);
    tests++;
    if (det_seen != d0) begin
      fails++;
      $display("FAIL single_short: %0d detections, want 0", det_seen - d0);
    end
  endtask

  task automatic test_rotate();
    logic [NCH-1:0] want [5];
    int d0;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    ch_en = '1;
    for (int i = 0; i < NCH; i++) push(i, "11");
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests++;
      if (last_rdy !== want[k]) begin
        fails++;
        $display("FAIL rotate_%0d: got %b, want %b", k, last_rdy, want[k]);
      end
    end
    run(20);
    do_reset();
    ch_en = '1;
    d0 = det_seen;
    push(0, "1110"); push(1, "10");
    run(30);
    tests++;
    if (det_seen - d0 != 1 || last_ch != 0 || last_len != 3) begin
      fails++;
      $display("FAIL interleave: n=%0d ch=%0d len=%0d, want 1 0 3", det_seen - d0, last_ch, last_len);
    end
  endtask

  task automatic test_enable();
    int d0;
    do_reset();
    ch_en = 4'b0010;
    d0 = det_seen;
    push(1, "11"); run(20);
    ch_en[1] = 1'b0; cycle();
    ch_en[1] = 1'b1;
    push(1, "0"); run(20);
    tests++;
    if (det_seen != d0) begin
      fails++;
      $display("FAIL enable_drop: %0d detections, want 0", det_seen - d0);
    end
    push(1, "110"); run(20);
    tests++;
    if (det_seen - d0 != 1 || last_ch != 1 || last_len != 2) begin
      fails++;
      $display("FAIL enable_det: n=%0d ch=%0d len=%0d, want 1 1 2", det_seen - d0, last_ch, last_len);
    end
  endtask

  task automatic test_saturate();
    int d0;
    do_reset();
    ch_en = 4'b1000;
    d0 = det_seen;
    for (int i = 0; i < 20; i++) push(3, "1");
    push(3, "0"); run(60);
    tests++;
    if (det_seen - d0 != 1 || last_ch != 3 || last_len != 15) begin
      fails++;
      $display("FAIL saturate: n=%0d ch=%0d len=%0d, want 1 3 15", det_seen - d0, last_ch, last_len);
    end
  endtask

  task automatic test_flush();
    int d0;
    do_reset();
    ch_en = 4'b0011;
    d0 = det_seen;
    push(0, "111"); run(20);
    push(1, "1");
    flush = 1'b1; cycle(); flush = 1'b0;
    tests++;
    if (last_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL flush_nogrant: got %b, want 0000", last_rdy);
    end
    push(0, "0");
    cycle();
    tests++;
    if (last_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL flush_ptr: got %b, want 0001", last_rdy);
    end
    run(20);
    tests++;
    if (det_seen != d0) begin
      fails++;
      $display("FAIL flush_nodet: %0d detections, want 0", det_seen - d0);
    end
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic test_counter();
    do_reset();
    ch_en = 4'b0010;
    for (int k = 0; k < 3; k++) begin push(1, "110"); run(20); end
    cycle();
    cnt_sel = 2'd1;
    #1;
    tests++;
    if (cnt_data !== 16'd3) begin
      fails++;
      $display("FAIL cnt_read: got %0d, want 3", cnt_data);
    end
    flush = 1'b1; cycle(); flush = 1'b0;
    #1;
    tests++;
    if (cnt_data !== 16'd0) begin
      fails++;
      $display("FAIL cnt_flush: got %0d, want 0", cnt_data);
    end
  endtask
`endif

  initial begin
    det_seen = 0; last_ch = -1; last_len = -1; mptr = 0;
    for (int i = 0; i < NCH; i++) mctx[i] = 0;
    test_reset();
    test_single();
    test_rotate();
    test_enable();
    test_saturate();
    test_flush();
`ifdef SEQ_DET_COUNT_EN
    test_counter();
`endif
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_sb: %0d expected detections pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
